// File: rtl/knight_sprite_addr_gen_pkg.sv
// Shared constants and types for the knight sprite address generator.
// Sprite geometry and animation pacing live here so the FSM and the pipeline agree.
package knight_sprite_pkg;

  localparam int SPR_W      = 50;
  localparam int SPR_H      = 64;
  localparam int NUM_FRAMES = 4;
  localparam int ANIM_DIV   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

  typedef logic [1:0] frame_idx_t;

endpackage

// File: rtl/knight_sprite_addr_gen_if.sv
// Pixel-side bus between the VGA scan logic and the knight sprite address generator.
// The scan side (master) drives coordinates/blank; the generator (slave) returns ROM address, frame and hit.
interface knight_sprite_addr_gen_if #(
  parameter int ADDR_W = 12
);
  import knight_sprite_pkg::*;

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic [ADDR_W-1:0] rom_address;
  frame_idx_t        frame_sel;
  logic              sprite_hit;

  modport master (
    output DrawX, DrawY, blank,
    input  rom_address, frame_sel, sprite_hit
  );

  modport slave (
    input  DrawX, DrawY, blank,
    output rom_address, frame_sel, sprite_hit
  );

endinterface

// File: rtl/knight_sprite_addr_gen_anim_fsm.sv
// Walk-animation sequencer: steps the walk frame once every ANIM_DIV frame ticks while walking.
// Everything advances only on frame_tick so the frame never changes mid-scan.
module knight_anim_fsm
  import knight_sprite_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       walking,
  output frame_idx_t frame_sel
);

  localparam int DIV_W = $clog2(ANIM_DIV);

  anim_state_t      state_q;
  logic [DIV_W-1:0] div_cnt_q;
  frame_idx_t       frame_idx_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      frame_idx_q <= '0;
    end else if (frame_tick) begin
      case (state_q)
        IDLE: begin
          // The entering tick only arms the walk; the first frame step comes ANIM_DIV ticks later.
          div_cnt_q   <= '0;
          frame_idx_q <= '0;
          if (walking) state_q <= WALK;
        end
        WALK: begin
          if (!walking) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            frame_idx_q <= '0;
          end else if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
            div_cnt_q   <= '0;
            frame_idx_q <= (frame_idx_q == frame_idx_t'(NUM_FRAMES - 1)) ? '0 : frame_idx_q + 1'b1;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          div_cnt_q   <= '0;
          frame_idx_q <= '0;
        end
      endcase
    end
  end

  assign frame_sel = frame_idx_q;

endmodule

// File: rtl/knight_sprite_addr_gen.sv
// Knight sprite hit test and ROM address generator with a 2-cycle pixel pipeline.
// Position and facing are shadow-latched on frame_tick so a frame always renders one consistent pose.
module knight_sprite_addr_gen
  import knight_sprite_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic [9:0]                knight_x,
  input  logic [9:0]                knight_y,
  input  logic                      walking,
  input  logic                      facing_left,
  knight_sprite_addr_gen_if.slave   pix
);

  localparam int COL_W  = $clog2(SPR_W);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int MUL_W  = $clog2(SPR_W + 1);
  localparam logic [31:0] SPR_W_BITS = SPR_W;

  logic [9:0]        lx_q, lx_d;
  logic [9:0]        ly_q, ly_d;
  logic              facing_q, facing_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              hit1_q, hit1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;

  logic [10:0]       dx, dy;
  logic [COL_W-1:0]  dx_lo;
  logic              in_box;
  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] psum [0:MUL_W];

  // Row * SPR_W as a sum of shifted rows, one adder per set bit of SPR_W (50 -> <<5, <<4, <<1).
  assign row_ext = ADDR_W'(row_q);
  assign psum[0] = '0;
  for (genvar gi = 0; gi < MUL_W; gi++) begin : g_mul
    if (SPR_W_BITS[gi]) begin : g_add
      assign psum[gi+1] = psum[gi] + (row_ext << gi);
    end else begin : g_pass
      assign psum[gi+1] = psum[gi];
    end
  end

  always_comb begin
    lx_d     = frame_tick ? knight_x    : lx_q;
    ly_d     = frame_tick ? knight_y    : ly_q;
    facing_d = frame_tick ? facing_left : facing_q;

    // Bit 10 is the borrow: pixel left of / above the box, which also stops wrap-around.
    dx     = {1'b0, pix.DrawX} - {1'b0, lx_q};
    dy     = {1'b0, pix.DrawY} - {1'b0, ly_q};
    in_box = !dx[10] && !dy[10] && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
    dx_lo  = dx[COL_W-1:0];

    col_d  = facing_q ? (COL_W'(SPR_W - 1) - dx_lo) : dx_lo;
    row_d  = dy[ROW_W-1:0];
    hit1_d = in_box & pix.blank;

    addr_d = hit1_q ? (psum[MUL_W] + ADDR_W'(col_q)) : '0;
    hit_d  = hit1_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      lx_q     <= '0;
      ly_q     <= '0;
      facing_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      hit1_q   <= 1'b0;
      addr_q   <= '0;
      hit_q    <= 1'b0;
    end else begin
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      facing_q <= facing_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hit1_q   <= hit1_d;
      addr_q   <= addr_d;
      hit_q    <= hit_d;
    end
  end

  assign pix.rom_address = addr_q;
  assign pix.sprite_hit  = hit_q;

  knight_anim_fsm u_anim (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .walking    (walking),
    .frame_sel  (pix.frame_sel)
  );

endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// Self-checking bench for knight_sprite_addr_gen against a plain-arithmetic sprite/animation model.
module tb_knight_sprite_addr_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       walking = 1'b0;
  logic       facing_left = 1'b0;
  logic [9:0] knight_x = '0;
  logic [9:0] knight_y = '0;

  knight_sprite_addr_gen_if pix_if ();

  knight_sprite_addr_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .knight_x    (knight_x),
    .knight_y    (knight_y),
    .walking     (walking),
    .facing_left (facing_left),
    .pix         (pix_if)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  // model state: latched pose and walk-tick count
  int m_lx = 0, m_ly = 0;
  bit m_fl = 0, m_walk = 0;
  int m_n = 0, m_frame = 0;

  function automatic void model_latch(input int x, input int y, input bit fl, input bit wk);
    m_lx = x; m_ly = y; m_fl = fl;
    if (wk) begin
      if (m_walk) m_n++;
      else begin m_walk = 1; m_n = 1; end
      m_frame = ((m_n - 1) / 6) % 4;
    end else begin
      m_walk = 0; m_n = 0; m_frame = 0;
    end
  endfunction

  function automatic void model_reset();
    m_lx = 0; m_ly = 0; m_fl = 0; m_walk = 0; m_n = 0; m_frame = 0;
  endfunction

  function automatic void model_pix(input int x, input int y, input bit b, output bit hit, output int addr);
    int dx, dy;
    dx = x - m_lx;
    dy = y - m_ly;
    hit  = b && dx >= 0 && dx < 50 && dy >= 0 && dy < 64;
    addr = hit ? dy * 50 + (m_fl ? 49 - dx : dx) : 0;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic set_pix(input int x, input int y, input bit b);
    pix_if.DrawX = 10'(x);
    pix_if.DrawY = 10'(y);
    pix_if.blank = b;
  endtask

  task automatic do_tick(input int x, input int y, input bit fl, input bit wk);
    knight_x = 10'(x); knight_y = 10'(y); facing_left = fl; walking = wk;
    frame_tick = 1'b1;
    @(posedge vga_clk); #1;
    frame_tick = 1'b0;
    model_latch(x, y, fl, wk);
  endtask

  task automatic test_reset();
    set_pix(0, 0, 1'b1);
    repeat (3) @(posedge vga_clk);
    #1;
    checks++;
    if (pix_if.sprite_hit !== 1'b0 || pix_if.rom_address !== 12'd0 || pix_if.frame_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset: hit=%0b addr=%0d frame=%0d, expected 0/0/0",
               pix_if.sprite_hit, pix_if.rom_address, pix_if.frame_sel);
    end
    reset_n = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int xs[4] = '{100, 149, 150, 99};
    int ys[4] = '{200, 263, 200, 200};
    bit eh; int ea;
    do_tick(100, 200, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_pix(xs[i], ys[i], 1'b1);
      model_pix(xs[i], ys[i], 1'b1, eh, ea);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      checks++;
      if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
        errors++;
        $display("FAIL basic (%0d,%0d): hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 xs[i], ys[i], pix_if.sprite_hit, pix_if.rom_address, eh, ea);
      end
    end
    $display("test_basic done");
  endtask

  task automatic test_mirror();
    int xs[3] = '{100, 149, 120};
    int ys[3] = '{200, 201, 263};
    bit eh; int ea;
    do_tick(100, 200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_pix(xs[i], ys[i], 1'b1);
      model_pix(xs[i], ys[i], 1'b1, eh, ea);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      checks++;
      if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
        errors++;
        $display("FAIL mirror (%0d,%0d): hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 xs[i], ys[i], pix_if.sprite_hit, pix_if.rom_address, eh, ea);
      end
    end
    $display("test_mirror done");
  endtask

  task automatic test_clip();
    int xs[8] = '{620, 639, 619, 620, 0,   620, 0, 10};
    int ys[8] = '{450, 479, 450, 449, 450, 0,   0, 14};
    bit eh; int ea;
    do_tick(620, 450, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_pix(xs[i], ys[i], 1'b1);
      model_pix(xs[i], ys[i], 1'b1, eh, ea);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      checks++;
      if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
        errors++;
        $display("FAIL clip (%0d,%0d): hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 xs[i], ys[i], pix_if.sprite_hit, pix_if.rom_address, eh, ea);
      end
    end
    // Offscreen horizontal position must never hit anywhere on the line.
    do_tick(700, 100, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int x;
      x = (i == 0) ? 639 : (i == 1) ? 0 : $urandom_range(0, 639);
      set_pix(x, 120, 1'b1);
      model_pix(x, 120, 1'b1, eh, ea);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      checks++;
      if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
        errors++;
        $display("FAIL offscreen (%0d,120): hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 x, pix_if.sprite_hit, pix_if.rom_address, eh, ea);
      end
    end
    $display("test_clip done");
  endtask

  task automatic test_shadow();
    int xs[4] = '{100, 300, 310, 100};
    int ys[4] = '{200, 300, 310, 200};
    bit bs[4] = '{1, 1, 0, 1};
    bit eh; int ea;
    do_tick(100, 200, 1'b0, 1'b0);
    // position changes without a tick are ignored
    knight_x = 10'd300; knight_y = 10'd300;
    for (int i = 0; i < 2; i++) begin
      set_pix(xs[i], ys[i], 1'b1);
      model_pix(xs[i], ys[i], 1'b1, eh, ea);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      checks++;
      if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
        errors++;
        $display("FAIL no_tick (%0d,%0d): hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 xs[i], ys[i], pix_if.sprite_hit, pix_if.rom_address, eh, ea);
      end
    end
    // tick in the same cycle as an in-box pixel: that pixel uses the old position
    set_pix(100, 200, 1'b1);
    model_pix(100, 200, 1'b1, eh, ea);
    do_tick(300, 300, 1'b0, 1'b0);
    @(posedge vga_clk); #1;
    checks++;
    if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
      errors++;
      $display("FAIL tick_same_cycle: hit=%0b addr=%0d, expected hit=%0b addr=%0d",
               pix_if.sprite_hit, pix_if.rom_address, eh, ea);
    end
    for (int i = 0; i < 4; i++) begin
      set_pix(xs[i], ys[i], bs[i]);
      model_pix(xs[i], ys[i], bs[i], eh, ea);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      checks++;
      if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
        errors++;
        $display("FAIL moved (%0d,%0d,b=%0b): hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 xs[i], ys[i], bs[i], pix_if.sprite_hit, pix_if.rom_address, eh, ea);
      end
    end
    $display("test_shadow done");
  endtask

  task automatic test_anim();
    for (int t = 1; t <= 25; t++) begin
      do_tick(100, 200, 1'b0, 1'b1);
      checks++;
      if (pix_if.frame_sel !== 2'(m_frame)) begin
        errors++;
        $display("FAIL anim tick %0d: frame_sel=%0d, expected %0d", t, pix_if.frame_sel, m_frame);
      end
    end
    do_tick(100, 200, 1'b0, 1'b0);
    checks++;
    if (pix_if.frame_sel !== 2'd0) begin
      errors++;
      $display("FAIL anim stop: frame_sel=%0d, expected 0", pix_if.frame_sel);
    end
    $display("test_anim done");
  endtask

  task automatic test_random();
    bit qh[$];
    int qa[$];
    bit eh, ph; int ea, pa;
    for (int i = 0; i < 400; i++) begin
      int x, y, nx, ny;
      bit b, tk, nf, wk;
      if (qh.size() == 2) begin
        ph = qh.pop_front(); pa = qa.pop_front();
        checks++;
        if (pix_if.sprite_hit !== ph || pix_if.rom_address !== 12'(pa)) begin
          errors++;
          $display("FAIL random step %0d: hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                   i, pix_if.sprite_hit, pix_if.rom_address, ph, pa);
        end
      end
      x = clamp(m_lx + $urandom_range(0, 69) - 10, 0, 639);
      y = clamp(m_ly + $urandom_range(0, 83) - 10, 0, 479);
      if ($urandom_range(0, 7) == 0) x = $urandom_range(0, 639);
      b = ($urandom_range(0, 3) != 0);
      model_pix(x, y, b, eh, ea);
      qh.push_back(eh); qa.push_back(ea);
      set_pix(x, y, b);
      tk = ($urandom_range(0, 15) == 0);
      nx = $urandom_range(0, 720); ny = $urandom_range(0, 500);
      nf = 1'($urandom_range(0, 1)); wk = 1'($urandom_range(0, 1));
      knight_x = 10'(nx); knight_y = 10'(ny); facing_left = nf; walking = wk;
      frame_tick = tk;
      @(posedge vga_clk); #1;
      frame_tick = 1'b0;
      if (tk) model_latch(nx, ny, nf, wk);
    end
    for (int k = 0; k < 2; k++) begin
      ph = qh.pop_front(); pa = qa.pop_front();
      checks++;
      if (pix_if.sprite_hit !== ph || pix_if.rom_address !== 12'(pa)) begin
        errors++;
        $display("FAIL random flush %0d: hit=%0b addr=%0d, expected hit=%0b addr=%0d",
                 k, pix_if.sprite_hit, pix_if.rom_address, ph, pa);
      end
      set_pix(0, 0, 1'b0);
      @(posedge vga_clk); #1;
    end
    checks++;
    if (pix_if.frame_sel !== 2'(m_frame)) begin
      errors++;
      $display("FAIL random frame_sel: got %0d, expected %0d", pix_if.frame_sel, m_frame);
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    bit eh; int ea;
    do_tick(100, 200, 1'b0, 1'b0);
    for (int t = 0; t < 13; t++) do_tick(100, 200, 1'b0, 1'b1);
    checks++;
    if (pix_if.frame_sel !== 2'd2 || m_frame != 2) begin
      errors++;
      $display("FAIL pre_reset frame_sel: got %0d, expected 2", pix_if.frame_sel);
    end
    set_pix(110, 210, 1'b1);
    model_pix(110, 210, 1'b1, eh, ea);
    @(posedge vga_clk); @(posedge vga_clk); #1;
    checks++;
    if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea)) begin
      errors++;
      $display("FAIL pre_reset pixel: hit=%0b addr=%0d, expected hit=%0b addr=%0d",
               pix_if.sprite_hit, pix_if.rom_address, eh, ea);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pix_if.sprite_hit !== 1'b0 || pix_if.rom_address !== 12'd0 || pix_if.frame_sel !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: hit=%0b addr=%0d frame=%0d, expected 0/0/0",
               pix_if.sprite_hit, pix_if.rom_address, pix_if.frame_sel);
    end
    @(posedge vga_clk); #1;
    reset_n = 1'b1;
    model_reset();
    // no tick yet: position is (0,0), facing right
    set_pix(10, 10, 1'b1);
    model_pix(10, 10, 1'b1, eh, ea);
    @(posedge vga_clk); @(posedge vga_clk); #1;
    checks++;
    if (pix_if.sprite_hit !== eh || pix_if.rom_address !== 12'(ea) || pix_if.frame_sel !== 2'd0) begin
      errors++;
      $display("FAIL post_reset pixel: hit=%0b addr=%0d frame=%0d, expected hit=%0b addr=%0d frame=0",
               pix_if.sprite_hit, pix_if.rom_address, pix_if.frame_sel, eh, ea);
    end
    for (int t = 1; t <= 7; t++) begin
      do_tick(100, 200, 1'b0, 1'b1);
      checks++;
      if (pix_if.frame_sel !== 2'(m_frame)) begin
        errors++;
        $display("FAIL post_reset walk tick %0d: frame_sel=%0d, expected %0d", t, pix_if.frame_sel, m_frame);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    set_pix(0, 0, 1'b0);
    test_reset();
    test_basic();
    test_mirror();
    test_clip();
    test_shadow();
    test_anim();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/knight_sprite_addr_gen.md
Name: knight_sprite_addr_gen

Overview:
- Upstream stage of the knight sprite ROM/palette renderer.
- Each pixel, it decides whether (DrawX, DrawY) lies inside the 50x64 knight box at the latched knight position, and computes the local ROM address, mirrored horizontally when the knight faces left.
- It also runs the walk-animation frame sequencer, which selects one of the walk-frame ROMs.
- Outputs are pipelined and aligned so the downstream ROM (read on negedge) and palette stage can consume them directly.

Parameters:
- SPR_W, 50, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- NUM_FRAMES, 4, walk frames in the cycle (frame 0 is also the idle pose)
- ANIM_DIV, 6, frame_tick pulses per animation step
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H

Ports:
- vga_clk, input, 1, pixel clock; the only clock
- reset_n, input, 1, asynchronous active-low reset
- DrawX, input, 10, current pixel column
- DrawY, input, 10, current pixel row
- blank, input, 1, high = active video
- frame_tick, input, 1, single-cycle pulse once per frame at vertical retrace
- knight_x, input, 10, requested top-left column
- knight_y, input, 10, requested top-left row
- walking, input, 1, knight is moving
- facing_left, input, 1, mirror the sprite horizontally
- rom_address, output, ADDR_W, local sprite address = row*SPR_W + col
- frame_sel, output, 2, walk-frame ROM select
- sprite_hit, output, 1, pixel lies inside the sprite box and blank is high

Behaviour:
- Reset: all pipeline registers, latched position/facing, anim state, anim counters, rom_address, frame_sel and sprite_hit clear to 0; FSM enters IDLE.
- Shadow latch:
  - knight_x, knight_y and facing_left are sampled only on cycles where frame_tick=1.
  - This prevents mid-frame tearing.
  - Values presented between ticks are ignored until the next tick.
- Animation FSM, states IDLE and WALK, advances only on frame_tick:
  - IDLE: frame_idx=0, div_cnt=0. On a tick with walking=1 go to WALK; frame_idx stays 0 on that tick.
  - WALK, tick with walking=0: go to IDLE, frame_idx=0, div_cnt=0.
  - WALK, tick with walking=1: div_cnt increments. When div_cnt==ANIM_DIV-1, div_cnt wraps to 0 and frame_idx advances, wrapping NUM_FRAMES-1 -> 0.
  - frame_sel = frame_idx, registered; changes take effect the cycle after the tick.
- Pixel pipeline, 2-cycle latency from DrawX/DrawY/blank to outputs:
  - Stage 1:
    - dx = DrawX - lx, dy = DrawY - ly, both 11-bit unsigned with borrow.
    - in_box = no borrow on either, dx < SPR_W, dy < SPR_H.
    - col = facing_l ? (SPR_W-1-dx) : dx.
    - Register col, dy, in_box & blank.
  - Stage 2:
    - rom_address = dy*SPR_W + col, with the multiply by 50 done as (dy<<5)+(dy<<4)+(dy<<1); no hardware multiplier.
    - sprite_hit = registered in_box & blank.
  - When sprite_hit=0, rom_address is forced to 0.
- Boundaries:
  - Box extending past 639/479 is clipped naturally; no wrap-around to column 0 or row 0.
  - knight_x > 639 produces no hits.
  - frame_tick coinciding with an in-box pixel: that pixel uses the old latched values; new values apply from the next cycle.
  - Reset asserted mid-frame: outputs go to 0 asynchronously. After release, the first hit requires a frame_tick to reload the position; until then position is (0,0) and facing is right.
- The maximum address, SPR_W*SPR_H-1 = 3199, must be reached exactly at local (49,63), unmirrored.

Decomposition:
- Package knight_sprite_pkg holds:
  - SPR_W, SPR_H, NUM_FRAMES, ANIM_DIV constants
  - anim_state_t enum {IDLE, WALK}
  - typedef frame_idx_t (2-bit)
- One natural sub-module: knight_anim_fsm, containing the FSM, div counter and frame index.
- The address pipeline stays in the top module.

Test Plan:
- Reset release, tick with knight_x=100, knight_y=200, facing right, sweep (100,200) -> 2 cycles later sprite_hit=1, rom_address=0. (149,263) -> rom_address=3199. (150,200) -> sprite_hit=0, rom_address=0.
- facing_left=1 latched, pixel (100,200) -> rom_address=49. Pixel (149,201) -> rom_address=50.
- walking=1 for 25 ticks -> frame_sel sequence: 0 for ticks 1-6, 1 for 7-12, 2 for 13-18, 3 for 19-24, 0 at tick 25. Then walking=0, one tick -> IDLE, frame_sel=0.
- knight_x=620, knight_y=450 -> hits only for DrawX 620..639 and DrawY 450..479. No hit at DrawX=0 or DrawY=0.
- Change knight_x without a tick -> hit region unchanged. After a tick -> region moves. blank=0 inside the box -> sprite_hit=0.
- Assert reset_n=0 mid-line while walking at frame 2 -> outputs 0 immediately. After release -> frame_sel=0, FSM in IDLE.
